mem_responder: RTL and testbench

Word-addressed memory responder for the CPU datapath's memory interface. It accepts Read/Write requests carrying the MAR address and MDR write data. It inserts a programmable number of wait states and performs a single-port synchronous array access. It returns read data on `Mdatain` with a one-cycle `Ready` completion pulse, and replaces the hand-driven `Mdatain` stimulus used in earlier datapath benches.

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_array.sv | 23 ++
 rtl/mem_responder.sv | 127 ++++++++++++
 tb/tb_mem_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding and defaults.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE
  } mem_state_t;

  localparam int unsigned DEFAULT_WAIT_STATES = 1;
  localparam int unsigned MEM_DATA_WIDTH      = 32;
  localparam int unsigned WAIT_CNT_WIDTH      = 4;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with registered read data; contents are not reset.
module mem_array #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  // Read-first: rdata reflects the word before a same-edge write.
  always_ff @(posedge Clock) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder: accepts Read/Write strobes, inserts wait
// states, accesses the array and returns data with a one-cycle Ready pulse.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned DATA_WIDTH  = MEM_DATA_WIDTH,
  parameter int unsigned WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [ADDR_WIDTH-1:0] MAR_addr,
  input  logic [DATA_WIDTH-1:0] MDR_data,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  Ready,
  output logic                  Busy,
  output logic                  Err
);

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(WAIT_STATES);
  localparam logic                      NO_WAIT   = (WAIT_STATES == 0);

  mem_state_t                r_state;
  logic                      r_armed;
  logic [WAIT_CNT_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic                      r_is_read;
  logic [DATA_WIDTH-1:0]     r_mdatain;
  logic                      r_ready;
  logic                      r_busy;
  logic                      r_err;

  logic                      w_accept;
  logic                      w_we;
  logic [ADDR_WIDTH-1:0]     w_arr_addr;
  logic [DATA_WIDTH-1:0]     w_rdata;

  assign w_accept = (r_state == ST_IDLE) && r_armed && (Read || Write);
  assign w_we     = (r_state == ST_ACCESS) && !r_is_read;

  // The array is read one edge ahead of ACCESS (from MAR_addr while idle, so a
  // zero-wait read still works) so Mdatain can be a plain flop loaded on ACCESS.
  assign w_arr_addr = (r_state == ST_IDLE) ? MAR_addr : r_addr;

  mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem_array (
    .Clock (Clock),
    .we    (w_we),
    .addr  (w_arr_addr),
    .wdata (r_wdata),
    .rdata (w_rdata)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state   <= ST_IDLE;
      r_armed   <= 1'b1;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_is_read <= 1'b0;
      r_mdatain <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      if (!Read && !Write) begin
        r_armed <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_armed   <= 1'b0;
            r_addr    <= MAR_addr;
            r_wdata   <= MDR_data;
            r_is_read <= Read && !Write;
            r_cnt     <= WAIT_LOAD;
            r_busy    <= 1'b1;
            if (Read && Write) begin
              r_state <= ST_DONE;
              r_ready <= 1'b1;
              r_err   <= 1'b1;
            end else if (NO_WAIT) begin
              r_state <= ST_ACCESS;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == WAIT_CNT_WIDTH'(1)) begin
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_is_read) begin
            r_mdatain <= w_rdata;
          end
          r_ready <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Mdatain = r_mdatain;
  assign Ready   = r_ready;
  assign Busy    = r_busy;
  assign Err     = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: three responders (W=1, W=3, W=0) against a word-array model.
module tb_mem_responder;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;
  localparam int unsigned N  = 3;

  function automatic int unsigned ws_of(input int unsigned i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
  endfunction

  logic          clk;
  logic          rst_n;
  logic          rd   [N];
  logic          wr   [N];
  logic [AW-1:0] addr [N];
  logic [DW-1:0] wdat [N];
  logic [DW-1:0] mdat [N];
  logic          rdy  [N];
  logic          busy [N];
  logic          err  [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .WAIT_STATES(ws_of(g))
    ) u_dut (
      .Clock   (clk),
      .Resetn  (rst_n),
      .Read    (rd[g]),
      .Write   (wr[g]),
      .MAR_addr(addr[g]),
      .MDR_data(wdat[g]),
      .Mdatain (mdat[g]),
      .Ready   (rdy[g]),
      .Busy    (busy[g]),
      .Err     (err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: word array per unit, which words are known, last read data.
  logic [DW-1:0] mem_m   [N][512];
  bit            valid_m [N][512];
  logic [DW-1:0] mdat_m  [N];

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Starts and ends at a negedge. hold = cycles the strobe stays high (0: dropped right after accept).
  task automatic txn(input int unsigned i, input bit r, input bit w,
                     input logic [AW-1:0] a, input logic [DW-1:0] d, input int unsigned hold);
    int unsigned last, stop;
    bit illegal;
    illegal = r && w;
    last    = illegal ? 0 : ws_of(i) + 1;
    stop    = (hold > last + 1) ? hold : last + 1;
    rd[i] = r; wr[i] = w; addr[i] = a; wdat[i] = d;
    @(posedge clk);
    #1;
    addr[i] = AW'($urandom);
    wdat[i] = $urandom;
    if (hold == 0) begin
      rd[i] = 1'b0; wr[i] = 1'b0;
    end
    for (int unsigned j = 0; j <= stop; j++) begin
      @(negedge clk);
      if (j == last && !illegal) begin
        if (r) mdat_m[i] = mem_m[i][a];
        else begin
          mem_m[i][a]   = d;
          valid_m[i][a] = 1'b1;
        end
      end
      check_eq($sformatf("u%0d a%0h ready c%0d", i, a, j), DW'(rdy[i]),  DW'(j == last));
      check_eq($sformatf("u%0d a%0h err c%0d", i, a, j),   DW'(err[i]),  DW'(illegal && j == last));
      check_eq($sformatf("u%0d a%0h busy c%0d", i, a, j),  DW'(busy[i]), DW'(j <= last));
      check_eq($sformatf("u%0d a%0h mdat c%0d", i, a, j),  mdat[i],      mdat_m[i]);
      if (hold != 0 && j + 1 == hold) begin
        rd[i] = 1'b0; wr[i] = 1'b0;
      end
      if (j < stop) @(posedge clk);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int unsigned i = 0; i < N; i++) begin
      check_eq($sformatf("%s u%0d mdat", tag, i),  mdat[i],       mdat_m[i]);
      check_eq($sformatf("%s u%0d ready", tag, i), DW'(rdy[i]),   '0);
      check_eq($sformatf("%s u%0d busy", tag, i),  DW'(busy[i]),  '0);
      check_eq($sformatf("%s u%0d err", tag, i),   DW'(err[i]),   '0);
    end
  endtask

  int unsigned   op, hold;
  logic [AW-1:0] ra;
  logic [DW-1:0] rdv;

  initial begin
    rst_n = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdat[i] = '0;
      mdat_m[i] = '0;
      for (int unsigned k = 0; k < 512; k++) valid_m[i][k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // W=1: write then read back the same word
    txn(0, 0, 1, 9'h010, 32'h28918000, 0);
    txn(0, 1, 0, 9'h010, 32'h0, 0);
    // Read held for 10 cycles: one transaction only
    txn(0, 0, 1, 9'h00C, 32'h0000000C, 0);
    txn(0, 1, 0, 9'h00C, 32'h0, 10);
    // Illegal request leaves the array and Mdatain untouched
    txn(0, 0, 1, 9'h020, 32'hDEADBEEF, 0);
    txn(0, 1, 1, 9'h020, 32'h0BADF00D, 0);
    txn(0, 1, 0, 9'h020, 32'h0, 0);
    // Top word and word 0 stay distinct
    txn(0, 0, 1, 9'h000, 32'h13579BDF, 0);
    txn(0, 0, 1, 9'h1FF, 32'h000000FF, 0);
    txn(0, 1, 0, 9'h1FF, 32'h0, 0);
    txn(0, 1, 0, 9'h000, 32'h0, 0);

    // W=0: back-to-back reads with the strobe low for a single sampled edge
    txn(2, 0, 1, 9'h001, 32'hA1A1A1A1, 0);
    txn(2, 0, 1, 9'h002, 32'hB2B2B2B2, 0);
    txn(2, 1, 0, 9'h001, 32'h0, 2);
    txn(2, 1, 0, 9'h002, 32'h0, 0);

    // W=3: reset pulsed during WAIT aborts a pending write
    txn(1, 0, 1, 9'h005, 32'hAAAA5555, 0);
    txn(1, 1, 0, 9'h005, 32'h0, 0);
    wr[1] = 1'b1; addr[1] = 9'h005; wdat[1] = 32'h12345678;
    @(posedge clk);
    #1;
    wr[1] = 1'b0; addr[1] = AW'($urandom); wdat[1] = $urandom;
    @(negedge clk);
    check_eq("u1 busy before reset", DW'(busy[1]), DW'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int unsigned i = 0; i < N; i++) mdat_m[i] = '0;
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq($sformatf("u1 post-reset ready c%0d", c), DW'(rdy[1]),  '0);
      check_eq($sformatf("u1 post-reset busy c%0d", c),  DW'(busy[1]), '0);
    end
    txn(1, 1, 0, 9'h005, 32'h0, 0);

    // Randomized traffic on each unit
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned n = 0; n < 30; n++) begin
        op   = $urandom_range(0, 9);
        hold = $urandom_range(0, 4);
        ra   = ($urandom_range(0, 7) == 0) ? 9'h1FF : AW'($urandom_range(0, 15));
        rdv  = $urandom;
        if (op == 9)
          txn(i, 1, 1, ra, rdv, hold);
        else if (op >= 4 && valid_m[i][ra])
          txn(i, 1, 0, ra, rdv, hold);
        else
          txn(i, 0, 1, ra, rdv, hold);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
